// File: rtl/render_scheduler.sv
// Per-frame sequencer: clears the frame/depth buffers, then walks the triangle
// list and hands one triangle at a time to the raster datapath.
module render_scheduler #(
    parameter int COORD_WIDTH    = 32,
    parameter int FB_WIDTH       = 320,
    parameter int FB_HEIGHT      = 180,
    parameter int TRI_ADDR_WIDTH = 8
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   frame_start,
    input  logic [TRI_ADDR_WIDTH:0]                num_tris,
    output logic [TRI_ADDR_WIDTH-1:0]              tri_addr,
    input  logic [9*COORD_WIDTH-1:0]               tri_data,
    output logic [9*COORD_WIDTH-1:0]               tri_verts,
    output logic                                   raster_start,
    input  logic                                   raster_done,
    output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  clear_addr,
    output logic                                   clear_we,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   overrun,
    output logic [2:0]                             sched_state
);

    localparam int CLEAR_AW = $clog2(FB_WIDTH*FB_HEIGHT);
    localparam logic [CLEAR_AW-1:0] CLEAR_LAST = CLEAR_AW'(FB_WIDTH*FB_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t                  state;
    logic [TRI_ADDR_WIDTH:0] tri_count;
    logic [TRI_ADDR_WIDTH:0] tri_idx;
    logic [TRI_ADDR_WIDTH:0] idx_next;
    logic [1:0]              wait_cnt;

    // Index is one bit wider than the address so a full list ends without wrapping.
    assign idx_next    = tri_idx + 1'b1;
    assign tri_addr    = tri_idx[TRI_ADDR_WIDTH-1:0];
    assign sched_state = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            tri_count    <= '0;
            tri_idx      <= '0;
            wait_cnt     <= '0;
            tri_verts    <= '0;
            clear_addr   <= '0;
            clear_we     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            raster_start <= 1'b0;
        end else begin
            overrun      <= frame_start && busy;
            frame_done   <= 1'b0;
            raster_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        tri_count  <= num_tris;
                        tri_idx    <= '0;
                        busy       <= 1'b1;
                        clear_addr <= '0;
                        clear_we   <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clear_addr == CLEAR_LAST) begin
                        clear_we <= 1'b0;
                        wait_cnt <= '0;
                        if (tri_count == '0) begin
                            frame_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                    end
                end
                // Memory returns data two cycles after the address; capture on the third.
                S_FETCH: begin
                    if (wait_cnt == 2'd2) begin
                        tri_verts    <= tri_data;
                        raster_start <= 1'b1;
                        state        <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (raster_done) begin
                        tri_idx  <= idx_next;
                        wait_cnt <= '0;
                        if (idx_next == tri_count) begin
                            frame_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler with a 4x2 framebuffer and a
// two-cycle triangle memory; expected timelines are hand-computed per test.
module tb_render_scheduler;

    localparam int CW  = 32;
    localparam int FBW = 4;
    localparam int FBH = 2;
    localparam int TAW = 8;
    localparam int CAW = $clog2(FBW*FBH);

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           frame_start;
    logic [TAW:0]   num_tris;
    logic [TAW-1:0] tri_addr;
    logic [9*CW-1:0] tri_data = '0;
    logic [9*CW-1:0] mem_d1   = '0;
    logic [9*CW-1:0] tri_verts;
    logic           raster_start;
    logic           raster_done;
    logic           manual_done;
    logic           auto_done = 1'b0;
    logic           auto_en;
    int             auto_cnt  = 0;
    logic [CAW-1:0] clear_addr;
    logic           clear_we;
    logic           busy;
    logic           frame_done;
    logic           overrun;
    logic [2:0]     sched_state;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    assign raster_done = manual_done | auto_done;

    render_scheduler #(
        .COORD_WIDTH(CW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .TRI_ADDR_WIDTH(TAW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .num_tris(num_tris),
        .tri_addr(tri_addr), .tri_data(tri_data), .tri_verts(tri_verts),
        .raster_start(raster_start), .raster_done(raster_done),
        .clear_addr(clear_addr), .clear_we(clear_we), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .sched_state(sched_state)
    );

    function automatic logic [9*CW-1:0] word_of(input int i);
        logic [CW-1:0] c;
        c = CW'(i + 1);
        return {9{c}};
    endfunction

    // Two-cycle read latency memory model.
    always @(posedge clk_in) begin
        mem_d1   <= word_of(int'(tri_addr));
        tri_data <= mem_d1;
    end

    // Datapath model: done arrives 20 cycles after each start.
    always @(posedge clk_in) begin
        auto_done <= 1'b0;
        if (auto_en && raster_start) begin
            auto_cnt <= 19;
        end else if (auto_cnt == 1) begin
            auto_done <= 1'b1;
            auto_cnt  <= 0;
        end else if (auto_cnt > 1) begin
            auto_cnt <= auto_cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] st;
        repeat (3) step();
        rst_in = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            st = {busy, clear_we, raster_start, frame_done, overrun};
            total++;
            if (st !== 5'b0) begin
                bad++;
                $display("[TB] FAIL reset_flags c=%0d got=%b want=00000", c, st);
            end
            total++;
            if (sched_state !== 3'd0 || clear_addr !== '0 || tri_addr !== '0) begin
                bad++;
                $display("[TB] FAIL reset_regs c=%0d got state=%0d ca=%0d ta=%0d want 0/0/0",
                         c, sched_state, clear_addr, tri_addr);
            end
            total++;
            if (tri_verts !== '0) begin
                bad++;
                $display("[TB] FAIL reset_verts c=%0d got=%0h want=0", c, tri_verts);
            end
        end
    endtask

    task automatic test_empty_frame();
        logic [4:0] st, ex;
        logic [2:0] es;
        step();
        frame_start = 1'b1;
        num_tris    = '0;
        for (int c = 1; c <= 10; c++) begin
            step();
            frame_start = 1'b0;
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = {(c <= 9), (c <= 8), 1'b0, (c == 9), 1'b0};
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL empty_flags c=%0d got=%b want=%b", c, st, ex);
            end
            es = (c <= 8) ? 3'd1 : (c == 9) ? 3'd5 : 3'd0;
            total++;
            if (sched_state !== es) begin
                bad++;
                $display("[TB] FAIL empty_state c=%0d got=%0d want=%0d", c, sched_state, es);
            end
            if (c <= 8) begin
                total++;
                if (clear_addr !== CAW'(c - 1)) begin
                    bad++;
                    $display("[TB] FAIL empty_clear_addr c=%0d got=%0d want=%0d", c, clear_addr, c - 1);
                end
            end
        end
    endtask

    task automatic test_three_tris();
        logic [4:0] st, ex;
        int pulses = 0;
        auto_en = 1'b1;
        step();
        frame_start = 1'b1;
        num_tris    = 9'd3;
        for (int c = 1; c <= 85; c++) begin
            step();
            frame_start = 1'b0;
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = {(c <= 81), (c <= 8), (c == 12 || c == 36 || c == 60), (c == 81), 1'b0};
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL tris_flags c=%0d got=%b want=%b", c, st, ex);
            end
            if (raster_start === 1'b1) begin
                total++;
                if (tri_verts !== word_of(pulses) || tri_addr !== TAW'(pulses)) begin
                    bad++;
                    $display("[TB] FAIL tris_issue n=%0d got ta=%0d v=%0h want ta=%0d v=%0h",
                             pulses, tri_addr, tri_verts[CW-1:0], pulses, word_of(pulses) & {CW{1'b1}});
                end
                pulses++;
            end
            if (c == 9 || c == 12 || c == 13) begin
                total++;
                if (sched_state !== ((c == 9) ? 3'd2 : (c == 12) ? 3'd3 : 3'd4)) begin
                    bad++;
                    $display("[TB] FAIL tris_state c=%0d got=%0d", c, sched_state);
                end
            end
            if (c == 32) begin
                total++;
                if (tri_verts !== word_of(0)) begin
                    bad++;
                    $display("[TB] FAIL tris_hold c=%0d got=%0h want=%0h", c, tri_verts, word_of(0));
                end
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("[TB] FAIL tris_pulse_count got=%0d want=3", pulses);
        end
    endtask

    task automatic test_ignored_done();
        logic [4:0] st, ex;
        logic [2:0] es;
        auto_en = 1'b0;
        step();
        frame_start = 1'b1;
        num_tris    = 9'd1;
        for (int c = 1; c <= 20; c++) begin
            step();
            frame_start = 1'b0;
            manual_done = (c == 3 || c == 12 || c == 18);
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = {(c <= 19), (c <= 8), (c == 12), (c == 19), 1'b0};
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL ignore_flags c=%0d got=%b want=%b", c, st, ex);
            end
            es = (c <= 8) ? 3'd1 : (c <= 11) ? 3'd2 : (c == 12) ? 3'd3 :
                 (c <= 18) ? 3'd4 : (c == 19) ? 3'd5 : 3'd0;
            total++;
            if (sched_state !== es) begin
                bad++;
                $display("[TB] FAIL ignore_state c=%0d got=%0d want=%0d", c, sched_state, es);
            end
        end
        manual_done = 1'b0;
    endtask

    task automatic test_overrun();
        logic [4:0] st, ex;
        auto_en = 1'b1;
        step();
        frame_start = 1'b1;
        num_tris    = 9'd1;
        for (int c = 1; c <= 45; c++) begin
            step();
            frame_start = (c == 20 || c == 33);
            num_tris    = (c >= 5) ? 9'd5 : 9'd1;
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = {(c <= 33), (c <= 8), (c == 12), (c == 33), (c == 21 || c == 34)};
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL overrun_flags c=%0d got=%b want=%b", c, st, ex);
            end
            if (c >= 34) begin
                total++;
                if (sched_state !== 3'd0) begin
                    bad++;
                    $display("[TB] FAIL overrun_idle c=%0d got=%0d want=0", c, sched_state);
                end
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [4:0] st, ex;
        auto_en = 1'b1;
        step();
        frame_start = 1'b1;
        num_tris    = 9'd3;
        for (int c = 1; c <= 60; c++) begin
            step();
            frame_start = 1'b0;
            rst_in      = (c == 40);
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = (c <= 40) ? {1'b1, (c <= 8), (c == 12 || c == 36), 1'b0, 1'b0} : 5'b0;
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL midrst_flags c=%0d got=%b want=%b", c, st, ex);
            end
            if (c == 40) begin
                total++;
                if (sched_state !== 3'd4 || tri_addr !== 8'd1) begin
                    bad++;
                    $display("[TB] FAIL midrst_pre c=%0d got state=%0d ta=%0d want 4/1", c, sched_state, tri_addr);
                end
            end
            if (c >= 41) begin
                total++;
                if (sched_state !== 3'd0 || tri_addr !== '0 || tri_verts !== '0) begin
                    bad++;
                    $display("[TB] FAIL midrst_post c=%0d got state=%0d ta=%0d v=%0h want 0/0/0",
                             c, sched_state, tri_addr, tri_verts);
                end
            end
        end
        frame_start = 1'b1;
        num_tris    = 9'd1;
        for (int d = 1; d <= 35; d++) begin
            step();
            frame_start = 1'b0;
            st = {busy, clear_we, raster_start, frame_done, overrun};
            ex = {(d <= 33), (d <= 8), (d == 12), (d == 33), 1'b0};
            total++;
            if (st !== ex) begin
                bad++;
                $display("[TB] FAIL restart_flags d=%0d got=%b want=%b", d, st, ex);
            end
            if (d == 1) begin
                total++;
                if (clear_addr !== '0) begin
                    bad++;
                    $display("[TB] FAIL restart_clear_addr got=%0d want=0", clear_addr);
                end
            end
            if (d == 9) begin
                total++;
                if (tri_addr !== '0 || sched_state !== 3'd2) begin
                    bad++;
                    $display("[TB] FAIL restart_fetch got ta=%0d state=%0d want 0/2", tri_addr, sched_state);
                end
            end
            if (d == 12) begin
                total++;
                if (tri_verts !== word_of(0)) begin
                    bad++;
                    $display("[TB] FAIL restart_verts got=%0h want=%0h", tri_verts, word_of(0));
                end
            end
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        frame_start = 1'b0;
        num_tris    = '0;
        manual_done = 1'b0;
        auto_en     = 1'b0;
        test_reset();
        test_empty_frame();
        test_three_tris();
        test_ignored_done();
        test_overrun();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
